// File: rtl/adam_aes_encipher_block.sv
// Iterative AES encipher datapath for the ADAM AES core.
// One round every 5 cycles: four SubBytes word passes through a shared 32-bit
// forward S-box, then one combined ShiftRows/MixColumns/AddRoundKey cycle.
// Round keys come from the external key memory, addressed by `round`.

// Forward S-box applied to the four bytes of one 32-bit word.
module adam_aes_sbox (
    input  logic [31:0] sboxw,
    output logic [31:0] new_sboxw
);
    localparam logic [7:0] SBOX_TABLE [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    assign new_sboxw = {SBOX_TABLE[sboxw[31:24]], SBOX_TABLE[sboxw[23:16]],
                        SBOX_TABLE[sboxw[15:8]],  SBOX_TABLE[sboxw[7:0]]};
endmodule

module adam_aes_encipher_block (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         next,
    input  logic         keylen,
    input  logic [127:0] block,
    output logic [3:0]   round,
    input  logic [127:0] round_key,
    output logic         ready,
    output logic [127:0] result
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_INIT = 2'd1,
        ST_SBOX = 2'd2,
        ST_MAIN = 2'd3
    } state_e;

    // GF(2^8) multiply-by-2 with reduction polynomial 0x11b.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // One MixColumns column: [2 3 1 1; 1 2 3 1; 1 1 2 3; 3 1 1 2].
    function automatic logic [31:0] mix_word(input logic [31:0] w);
        logic [7:0] b0, b1, b2, b3;
        {b0, b1, b2, b3} = w;
        return {xtime(b0) ^ xtime(b1) ^ b1 ^ b2 ^ b3,
                b0 ^ xtime(b1) ^ xtime(b2) ^ b2 ^ b3,
                b0 ^ b1 ^ xtime(b2) ^ xtime(b3) ^ b3,
                xtime(b0) ^ b0 ^ b1 ^ b2 ^ xtime(b3)};
    endfunction

    // Byte i = 4*col + row sits at bits [127-8i -: 8]; row r rotates left by r columns.
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int rr = 0; rr < 4; rr++) begin
                r[127 - 8 * (4 * c + rr) -: 8] = s[127 - 8 * (4 * ((c + rr) % 4) + rr) -: 8];
            end
        end
        return r;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        return {mix_word(s[127:96]), mix_word(s[95:64]), mix_word(s[63:32]), mix_word(s[31:0])};
    endfunction

    state_e        state_q, state_d;
    logic [127:0]  block_q, block_d;
    logic [3:0]    round_ctr_q, round_ctr_d;
    logic [1:0]    sword_ctr_q, sword_ctr_d;
    logic          keylen_q, keylen_d;
    logic          ready_q, ready_d;

    logic [31:0]   sboxw;
    logic [31:0]   new_sboxw;
    logic [127:0]  shifted;
    logic [3:0]    num_rounds;

    adam_aes_sbox u_sbox (
        .sboxw     (sboxw),
        .new_sboxw (new_sboxw)
    );

    assign shifted    = shift_rows(block_q);
    assign num_rounds = keylen_q ? 4'd14 : 4'd10;

    assign round  = round_ctr_q;
    assign ready  = ready_q;
    assign result = block_q;

    // Present the state word selected by sword_ctr to the shared S-box.
    always_comb begin
        unique case (sword_ctr_q)
            2'd0:    sboxw = block_q[127:96];
            2'd1:    sboxw = block_q[95:64];
            2'd2:    sboxw = block_q[63:32];
            default: sboxw = block_q[31:0];
        endcase
    end

    // Next-state and datapath updates for the round sequencer.
    always_comb begin
        // NOTE: every output gets a hold value first so no path leaves a latch.
        state_d     = state_q;
        block_d     = block_q;
        round_ctr_d = round_ctr_q;
        sword_ctr_d = sword_ctr_q;
        keylen_d    = keylen_q;
        ready_d     = ready_q;

        unique case (state_q)
            ST_IDLE: begin
                if (next) begin
                    ready_d     = 1'b0;
                    keylen_d    = keylen;
                    round_ctr_d = 4'd0;
                    state_d     = ST_INIT;
                end
            end
            ST_INIT: begin
                block_d     = block ^ round_key;
                round_ctr_d = 4'd1;
                sword_ctr_d = 2'd0;
                state_d     = ST_SBOX;
            end
            ST_SBOX: begin
                unique case (sword_ctr_q)
                    2'd0:    block_d[127:96] = new_sboxw;
                    2'd1:    block_d[95:64]  = new_sboxw;
                    2'd2:    block_d[63:32]  = new_sboxw;
                    default: block_d[31:0]   = new_sboxw;
                endcase
                sword_ctr_d = sword_ctr_q + 2'd1;
                if (sword_ctr_q == 2'd3) begin
                    state_d = ST_MAIN;
                end
            end
            default: begin // ST_MAIN
                if (round_ctr_q < num_rounds) begin
                    block_d     = mix_columns(shifted) ^ round_key;
                    round_ctr_d = round_ctr_q + 4'd1;
                    sword_ctr_d = 2'd0;
                    state_d     = ST_SBOX;
                end else begin
                    // Final round skips MixColumns; round_ctr holds.
                    block_d = shifted ^ round_key;
                    ready_d = 1'b1;
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    // State registers with asynchronous reset to the idle, ready condition.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            block_q     <= '0;
            round_ctr_q <= 4'd0;
            sword_ctr_q <= 2'd0;
            keylen_q    <= 1'b0;
            ready_q     <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments so every register sees pre-edge values.
            state_q     <= state_d;
            block_q     <= block_d;
            round_ctr_q <= round_ctr_d;
            sword_ctr_q <= sword_ctr_d;
            keylen_q    <= keylen_d;
            ready_q     <= ready_d;
        end
    end
endmodule
